// File: rtl/ram_burst_reader.sv
// Burst reader: fetches len words from base_addr (wrapping) over a read-only RAM port and streams them out. Optional stall counter: BURST_STALL_CNT_EN.
// Latency: first ram_en 1 cycle after start, first m_valid RD_LATENCY+2 cycles after start, 1 word/cycle sustained.
// Backpressure: m_ready low holds the FIFO head; reads pause once FIFO occupancy plus in-flight reads reaches FIFO_DEPTH.
module ram_burst_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en,
    input  logic [WIDTH-1:0]      ram_dout,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [15:0]           stall_cycles
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH:0]    remaining;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          inflight;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [WIDTH-1:0]       data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  last_mem;
    logic [RD_LATENCY-1:0]  cap_pipe, last_pipe;
    logic [CW:0]            occupancy;
    logic                   len_ok, accept, reject, credit_ok, fifo_wr, pop, last_pop;

    assign len_ok    = (len != '0) && (len <= MAX_LEN);
    assign accept    = (state == IDLE) && start && len_ok;
    assign reject    = (state == IDLE) && start && !len_ok;
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);
    assign fifo_wr   = cap_pipe[RD_LATENCY-1];
    assign m_valid   = (fifo_count != '0);
    assign m_data    = data_mem[rd_ptr];
    assign m_last    = m_valid && last_mem[rd_ptr];
    assign pop       = m_valid && m_ready;
    assign last_pop  = pop && m_last;
    assign ram_addr  = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                if ((remaining != '0) && credit_ok) begin
                    ram_en = 1'b1;
                    if (remaining == (ADDR_WIDTH+1)'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command bookkeeping and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            remaining <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (accept) begin
                addr_q    <= base_addr;
                remaining <= len;
            end
            if (reject) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
            if (ram_en) begin
                addr_q    <= addr_q + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH+1)'(1);
            end
            if ((state == DRAIN) && last_pop) done <= 1'b1;
        end
    end

    // The last-word flag travels with its read so m_last needs no word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_pipe  <= '0;
            last_pipe <= '0;
            inflight  <= '0;
        end else begin
            cap_pipe[0]  <= ram_en;
            last_pipe[0] <= ram_en && (remaining == (ADDR_WIDTH+1)'(1));
            for (int i = 1; i < RD_LATENCY; i++) begin
                cap_pipe[i]  <= cap_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            case ({ram_en, fifo_wr})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            last_mem   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) data_mem[i] <= '0;
        end else begin
            if (fifo_wr) begin
                data_mem[wr_ptr] <= ram_dout;
                last_mem[wr_ptr] <= last_pipe[RD_LATENCY-1];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({fifo_wr, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef BURST_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (busy && m_valid && !m_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: behavioural RAM plus a queue-based expected stream.
module tb_ram_burst_reader;
    localparam int AW  = 10;
    localparam int W   = 32;
    localparam int RDL = 1;
    localparam int FD  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, err, ram_en, m_valid, m_last;
    logic          m_ready = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_dout, m_data;
    logic [15:0]   stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] ram [1024];
    logic [W-1:0] ram_q1 = '0;
    logic [W-1:0] ram_q2 = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) ram_q1 <= ram[ram_addr];
        ram_q2 <= ram_q1;
    end
    assign ram_dout = (RDL == 2) ? ram_q2 : ram_q1;

    ram_burst_reader #(.ADDR_WIDTH(AW), .WIDTH(W), .RD_LATENCY(RDL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .err(err), .ram_addr(ram_addr), .ram_en(ram_en),
        .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .stall_cycles(stall_cycles)
    );

    // mode 0: always ready, 1: random ready, 2: ready low for stall_len cycles once stall_at words accepted
    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                             input int stall_at, input int stall_len, input int inject_cyc,
                             input string tag, output int first_en, output int first_vld,
                             output int last_hs, output int done_cyc, output int max_out);
        logic [W-1:0]  exp_q[$];
        bit            exp_last_q[$];
        logic [AW-1:0] idx, ea;
        logic [W-1:0]  prev_data;
        logic          prev_last, prev_hold;
        int            issued, hs, stalled, stall_seen, budget, exp_stall;
        for (int i = 0; i < int'(l); i++) begin
            idx = b + AW'(i);
            exp_q.push_back(ram[idx]);
            exp_last_q.push_back(i == int'(l) - 1);
        end
        first_en = -1; first_vld = -1; last_hs = -1; done_cyc = -1; max_out = 0;
        issued = 0; hs = 0; stalled = 0; stall_seen = 0; prev_hold = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        budget = 64 + 8 * int'(l) + stall_len;
        @(negedge clk);
        start = 1'b1; base_addr = b; len = l; m_ready = (mode != 1);
        for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == inject_cyc) begin
                start = 1'b1; base_addr = b + 10'h155; len = 11'd5;
            end
            if (mode == 1) m_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && hs == stall_at && stalled < stall_len) begin
                m_ready = 1'b0; stalled++;
            end else m_ready = 1'b1;
            #1;
            if (ram_en) begin
                if (first_en < 0) first_en = cyc;
                ea = b + AW'(issued);
                n_cmp++;
                if (issued >= int'(l) || ram_addr !== ea) begin
                    n_err++;
                    $display("FAIL %s read_addr: issue #%0d ram_addr=%h required %h (len %0d)", tag, issued, ram_addr, ea, l);
                end
                issued++;
                n_cmp++;
                if (issued - hs > FD) begin
                    n_err++;
                    $display("FAIL %s credit: outstanding=%0d required <= %0d", tag, issued - hs, FD);
                end
                if (issued - hs > max_out) max_out = issued - hs;
            end
            if (prev_hold) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    n_err++;
                    $display("FAIL %s hold: valid=%b data=%h last=%b required 1 %h %b", tag, m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (m_valid && !m_ready) stall_seen++;
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_word: data=%h required no word", tag, m_data);
                end else begin
                    if (m_data !== exp_q[0] || m_last !== exp_last_q[0]) begin
                        n_err++;
                        $display("FAIL %s word%0d: data=%h last=%b required %h %b", tag, hs, m_data, m_last, exp_q[0], exp_last_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(exp_last_q.pop_front());
                end
                hs++;
                last_hs = cyc;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            n_cmp++;
            if (done) begin
                done_cyc = cyc;
                if (busy !== 1'b0 || err !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s done_flags: busy=%b err=%b required 0 0", tag, busy, err);
                end
            end else if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s busy: cycle %0d busy=%b required 1", tag, cyc, busy);
            end
        end
        n_cmp++;
        if (done_cyc < 0) begin
            n_err++;
            $display("FAIL %s timeout: no done within %0d cycles, required done", tag, budget);
        end
        n_cmp++;
        if (hs != int'(l) || issued != int'(l)) begin
            n_err++;
            $display("FAIL %s count: delivered=%0d issued=%0d required %0d", tag, hs, issued, l);
        end
        n_cmp++;
        if (done_cyc != last_hs + 1) begin
            n_err++;
            $display("FAIL %s done_timing: done cycle %0d required %0d", tag, done_cyc, last_hs + 1);
        end
`ifdef BURST_STALL_CNT_EN
        exp_stall = stall_seen;
`else
        exp_stall = 0;
`endif
        n_cmp++;
        if (int'(stall_cycles) != exp_stall) begin
            n_err++;
            $display("FAIL %s stall_cycles: %0d required %0d", tag, stall_cycles, exp_stall);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s pulse_width: done=%b err=%b busy=%b required 0 0 0", tag, done, err, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({busy, done, err, ram_en, m_valid, m_last} !== 6'b0 || ram_addr !== '0 || m_data !== '0 || stall_cycles !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy/done/err/en/valid/last=%b addr=%h data=%h stall=%0d required all 0",
                     {busy, done, err, ram_en, m_valid, m_last}, ram_addr, m_data, stall_cycles);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int fe, fv, lh, dc, mo;
        run_burst(10'h010, 11'd4, 0, 0, 0, -1, "basic", fe, fv, lh, dc, mo);
        n_cmp++;
        if (fe != 1 || fv != RDL + 2) begin
            n_err++;
            $display("FAIL basic latency: first ram_en cycle %0d first valid cycle %0d required 1 and %0d", fe, fv, RDL + 2);
        end
        n_cmp++;
        if (lh - fv != 3) begin
            n_err++;
            $display("FAIL basic throughput: last handshake %0d cycles after first required 3", lh - fv);
        end
    endtask

    task automatic test_wrap();
        int fe, fv, lh, dc, mo;
        run_burst(10'h3FE, 11'd4, 0, 0, 0, -1, "wrap", fe, fv, lh, dc, mo);
    endtask

    task automatic test_stall();
        int fe, fv, lh, dc, mo;
        run_burst(10'h040, 11'd16, 2, 2, 10, -1, "stall", fe, fv, lh, dc, mo);
        n_cmp++;
        if (mo != FD) begin
            n_err++;
            $display("FAIL stall occupancy: max outstanding %0d required %0d", mo, FD);
        end
    endtask

    task automatic test_illegal_len();
        logic [AW:0] bad [3];
        bad[0] = 11'd0; bad[1] = 11'd1025; bad[2] = 11'd2047;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b1; base_addr = AW'($urandom_range(0, 1023)); len = bad[k];
            @(negedge clk);
            start = 1'b0;
            #1;
            n_cmp++;
            if ({done, err, busy, ram_en} !== 4'b1100) begin
                n_err++;
                $display("FAIL illegal_len %0d pulse: done/err/busy/en=%b required 1100", bad[k], {done, err, busy, ram_en});
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if ({done, err, busy, ram_en} !== 4'b0000) begin
                n_err++;
                $display("FAIL illegal_len %0d after: done/err/busy/en=%b required 0000", bad[k], {done, err, busy, ram_en});
            end
        end
    endtask

    task automatic test_ignore_start();
        int fe, fv, lh, dc, mo;
        run_burst(10'h020, 11'd16, 0, 0, 0, 3, "ignore_start", fe, fv, lh, dc, mo);
    endtask

    task automatic test_reset_midburst();
        int fe, fv, lh, dc, mo;
        @(negedge clk);
        start = 1'b1; base_addr = 10'h100; len = 11'd20; m_ready = 1'b0;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, err, ram_en, m_valid, m_last} !== 6'b0 || ram_addr !== '0 || m_data !== '0 || stall_cycles !== '0) begin
            n_err++;
            $display("FAIL reset_midburst: busy/done/err/en/valid/last=%b addr=%h data=%h stall=%0d required all 0",
                     {busy, done, err, ram_en, m_valid, m_last}, ram_addr, m_data, stall_cycles);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_midburst no_done: done=%b required 0", done);
            end
        end
        rst_n = 1'b1;
        run_burst(10'h000, 11'd2, 0, 0, 0, -1, "after_reset", fe, fv, lh, dc, mo);
    endtask

    task automatic test_random();
        int fe, fv, lh, dc, mo;
        run_burst(AW'($urandom_range(0, 1023)), 11'd1, 0, 0, 0, -1, "len1", fe, fv, lh, dc, mo);
        n_cmp++;
        if (fv != RDL + 2 || lh != fv) begin
            n_err++;
            $display("FAIL len1 timing: first valid %0d last handshake %0d required %0d for both", fv, lh, RDL + 2);
        end
        for (int k = 0; k < 6; k++)
            run_burst(AW'($urandom_range(0, 1023)), 11'($urandom_range(1, 40)), 1, 0, 0, -1,
                      $sformatf("random%0d", k), fe, fv, lh, dc, mo);
        run_burst(AW'($urandom_range(0, 1023)), 11'd1024, 0, 0, 0, -1, "len1024", fe, fv, lh, dc, mo);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 | 32'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_illegal_len();
        test_ignore_start();
        test_reset_midburst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
